// File: rtl/libar_key_ctrl.sv
// libar_key_ctrl
//   Synchronous replacement for the per-bit LIBAR latch used in locked
//   netlists. It loads an NCH-bit key serially (LSB = channel 0 first) and
//   then arms NCH channels. In the armed state, channel i copies key bit i into
//   lib[i] on a rising edge of trig[i]. That edge is detected against a
//   registered copy of trig.
//   The decrypted outputs are d_out = d_enc ^ lib ^ XNOR_MASK.
//
// Optional feature:
//   LIBAR_PARITY_EN - each load carries one extra trailing even-parity bit.
//     A mismatch enters ERROR, raises key_err and clears lib.
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      synchronous active-low reset
//   key_load   start / restart a serial key load
//   key_valid  key_sdi is valid this cycle
//   key_sdi    serial key bit, channel 0 first
//   trig       per-channel trigger level
//   d_enc      encrypted channel signals
//   d_out      decrypted channel signals (combinational from d_enc)
//   key_ready  high while armed (registered)
//   key_err    parity error flag (registered, 0 without the parity feature)
//   cap_cnt    saturating count of cycles with at least one accepted capture
module libar_key_ctrl #(
  parameter int             NCH       = 8,
  parameter logic [NCH-1:0] XNOR_MASK = {NCH{1'b0}},
  parameter int             CNTW      = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            key_load,
  input  logic            key_valid,
  input  logic            key_sdi,
  input  logic [NCH-1:0]  trig,
  input  logic [NCH-1:0]  d_enc,
  output logic [NCH-1:0]  d_out,
  output logic            key_ready,
  output logic            key_err,
  output logic [CNTW-1:0] cap_cnt
);

`ifdef LIBAR_PARITY_EN
  localparam int NBITS = NCH + 1;
`else
  localparam int NBITS = NCH;
`endif
  localparam int            CW   = $clog2(NBITS + 1);
  localparam logic [CW-1:0] LAST = CW'(NBITS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    ARMED = 2'd2
`ifdef LIBAR_PARITY_EN
    , ERROR = 2'd3
`endif
  } state_t;

  state_t          state_reg;
  logic [CW-1:0]   bit_cnt_reg;
  logic [NCH-1:0]  key_reg;
  logic [NCH-1:0]  lib_reg;
  logic [NCH-1:0]  trig_q;
  logic [CNTW-1:0] cap_cnt_reg;
  logic            key_ready_reg;
  logic            key_err_reg;

  logic [NCH-1:0]  rise;
  logic            cap_any;

  // trig_q follows trig in every state, so a trigger that is already high
  // when ARMED is entered shows no edge until it falls and rises again.
  assign rise    = trig & ~trig_q;
  assign cap_any = (state_reg == ARMED) && (|rise);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      bit_cnt_reg   <= '0;
      key_reg       <= '0;
      lib_reg       <= '0;
      trig_q        <= '0;
      cap_cnt_reg   <= '0;
      key_ready_reg <= 1'b0;
      key_err_reg   <= 1'b0;
    end else begin
      trig_q <= trig;

      if (cap_any && (cap_cnt_reg != {CNTW{1'b1}}))
        cap_cnt_reg <= cap_cnt_reg + 1'b1;

      case (state_reg)
        IDLE: begin
          if (key_load) begin
            state_reg   <= SHIFT;
            bit_cnt_reg <= '0;
          end
        end

        SHIFT: begin
          // key_load wins over a simultaneous key_valid, and that bit is dropped.
          if (key_load) begin
            bit_cnt_reg <= '0;
          end else if (key_valid) begin
`ifdef LIBAR_PARITY_EN
            if (bit_cnt_reg == LAST) begin
              // The trailing bit makes the total number of ones even.
              if (key_sdi == ^key_reg) begin
                state_reg     <= ARMED;
                key_ready_reg <= 1'b1;
              end else begin
                state_reg   <= ERROR;
                key_err_reg <= 1'b1;
                lib_reg     <= '0;
              end
            end else begin
              key_reg     <= {key_sdi, key_reg[NCH-1:1]};
              bit_cnt_reg <= bit_cnt_reg + 1'b1;
            end
`else
            key_reg     <= {key_sdi, key_reg[NCH-1:1]};
            bit_cnt_reg <= bit_cnt_reg + 1'b1;
            if (bit_cnt_reg == LAST) begin
              state_reg     <= ARMED;
              key_ready_reg <= 1'b1;
            end
`endif
          end
        end

        ARMED: begin
          // Captures still happen on the cycle key_load arrives.
          // lib keeps its value while a new key loads.
          lib_reg <= (lib_reg & ~rise) | (key_reg & rise);
          if (key_load) begin
            state_reg     <= SHIFT;
            bit_cnt_reg   <= '0;
            key_ready_reg <= 1'b0;
          end
        end

`ifdef LIBAR_PARITY_EN
        ERROR: begin
          lib_reg <= '0;
          if (key_load) begin
            state_reg   <= SHIFT;
            bit_cnt_reg <= '0;
            key_err_reg <= 1'b0;
          end
        end
`endif

        default: state_reg <= IDLE;
      endcase
    end
  end

  for (genvar gi = 0; gi < NCH; gi++) begin : g_unlock
    assign d_out[gi] = d_enc[gi] ^ lib_reg[gi] ^ XNOR_MASK[gi];
  end

  assign key_ready = key_ready_reg;
  assign key_err   = key_err_reg;
  assign cap_cnt   = cap_cnt_reg;

endmodule

// File: tb/tb_libar_key_ctrl.sv
// Directed testbench for libar_key_ctrl (NCH=8, XNOR_MASK=0, CNTW=8).
module tb_libar_key_ctrl;
  localparam int NCH  = 8;
  localparam int CNTW = 8;
`ifdef LIBAR_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif

  logic            clk = 1'b0;
  logic            rst_n;
  logic            key_load;
  logic            key_valid;
  logic            key_sdi;
  logic [NCH-1:0]  trig;
  logic [NCH-1:0]  d_enc;
  logic [NCH-1:0]  d_out;
  logic            key_ready;
  logic            key_err;
  logic [CNTW-1:0] cap_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  libar_key_ctrl #(.NCH(NCH), .XNOR_MASK(8'h00), .CNTW(CNTW)) dut (
    .clk(clk), .rst_n(rst_n), .key_load(key_load), .key_valid(key_valid),
    .key_sdi(key_sdi), .trig(trig), .d_enc(d_enc), .d_out(d_out),
    .key_ready(key_ready), .key_err(key_err), .cap_cnt(cap_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  // Restarts a load. The first cycle also presents a valid bit, which
  // key_load must drop. Then it shifts the key LSB first, plus the parity
  // bit when that feature is built. key_ready is checked after every bit.
  task automatic load_key(input logic [NCH-1:0] key, input bit gaps);
    logic [NCH:0] bits;
    int nb;
    bits = {^key, key};
    nb   = NCH + PB;
    key_load = 1'b1; key_valid = 1'b1; key_sdi = 1'b1;
    tick();
    key_load = 1'b0;
    for (int i = 0; i < nb; i++) begin
      key_valid = 1'b1; key_sdi = bits[i];
      tick();
      key_valid = 1'b0;
      check($sformatf("ready_bit%0d", i), 32'(key_ready), 32'(i == nb - 1));
      if (gaps) tick();
    end
  endtask

  task automatic pulse_trig(input logic [NCH-1:0] t);
    trig = t;
    tick();
    trig = '0;
  endtask

  initial begin
    rst_n = 1'b0; key_load = 1'b0; key_valid = 1'b0; key_sdi = 1'b0;
    trig = '0; d_enc = 8'hA5;
    tick(); tick();
    // 1: reset state
    check("rst_dout", 32'(d_out), 32'h A5);
    check("rst_ready", 32'(key_ready), 32'h0);
    check("rst_cnt", 32'(cap_cnt), 32'h0);
    check("rst_err", 32'(key_err), 32'h0);
    rst_n = 1'b1;
    tick();

    // A rise while IDLE is ignored.
    pulse_trig(8'hFF);
    tick();
    check("idle_trig_dout", 32'(d_out), 32'h A5);
    check("idle_trig_cnt", 32'(cap_cnt), 32'h0);

    // 2: load 3C with gaps, then a one-cycle trigger on all channels.
    load_key(8'h3C, 1'b1);
    check("armed_nocap", 32'(d_out), 32'h A5);
    pulse_trig(8'hFF);
    check("cap_3c_dout", 32'(d_out), 32'h99);
    check("cap_3c_cnt", 32'(cap_cnt), 32'h1);
    tick();
    check("cap_3c_hold", 32'(d_out), 32'h99);
    check("cap_3c_cnt2", 32'(cap_cnt), 32'h1);

    // 5: reset while armed clears everything.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("rst2_dout", 32'(d_out), 32'h A5);
    check("rst2_ready", 32'(key_ready), 32'h0);
    check("rst2_cnt", 32'(cap_cnt), 32'h0);

    // 3: trig[0] held high across ARMED entry.
    trig = 8'h01;
    load_key(8'h81, 1'b0);
    tick(); tick();
    check("held_dout", 32'(d_out), 32'h A5);
    check("held_cnt", 32'(cap_cnt), 32'h0);
    trig = 8'h00;
    tick();
    pulse_trig(8'h01);
    check("rerise_dout", 32'(d_out), 32'h A4);
    check("rerise_cnt", 32'(cap_cnt), 32'h1);
    // Two channels rising together count as one capture event.
    pulse_trig(8'h06);
    check("multi_cnt", 32'(cap_cnt), 32'h2);
    check("multi_dout", 32'(d_out), 32'h A4);

    // 4: abort after 5 bits, then load F0. lib is held during the load.
    key_load = 1'b1;
    tick();
    key_load = 1'b0;
    check("reload_ready", 32'(key_ready), 32'h0);
    check("reload_lib_held", 32'(d_out), 32'h A4);
    for (int i = 0; i < 5; i++) begin
      key_valid = 1'b1; key_sdi = 1'b1;
      tick();
    end
    key_valid = 1'b0;
    load_key(8'hF0, 1'b0);
    pulse_trig(8'hFF);
    check("f0_dout", 32'(d_out), 32'h55);
    check("f0_cnt", 32'(cap_cnt), 32'h3);
    // Zero-latency path from d_enc.
    d_enc = 8'h12;
    #1;
    check("comb_dout", 32'(d_out), 32'h E2);
    d_enc = 8'hA5;

    // Saturation of cap_cnt: 3 + 256 captures.
    for (int i = 0; i < 256; i++) begin
      pulse_trig(8'h80);
      tick();
    end
    check("cnt_sat", 32'(cap_cnt), 32'hFF);

`ifdef LIBAR_PARITY_EN
    // 6: wrong parity on key 3C.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    key_load = 1'b1;
    tick();
    key_load = 1'b0;
    for (int i = 0; i < NCH + 1; i++) begin
      key_valid = 1'b1;
      key_sdi = (i == NCH) ? 1'b1 : ((8'h3C >> i) & 8'h01) != 0;
      tick();
    end
    key_valid = 1'b0;
    check("perr_err", 32'(key_err), 32'h1);
    check("perr_ready", 32'(key_ready), 32'h0);
    pulse_trig(8'hFF);
    check("perr_nocap_dout", 32'(d_out), 32'h A5);
    check("perr_nocap_cnt", 32'(cap_cnt), 32'h0);
    key_load = 1'b1;
    tick();
    key_load = 1'b0;
    check("perr_clear", 32'(key_err), 32'h0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/libar_key_ctrl.md
Name: libar_key_ctrl

Overview:
- Parametrised synchronous successor to the per-bit LIBAR latch used in locked ISCAS netlists.
- Loads an NCH-bit key serially and arms NCH channels; each channel latches its key bit on a synchronously detected trigger rising edge.
- Unlocks its encrypted signal as d_out = d_enc XOR lib XOR XNOR_MASK.
- Sits between the key-delivery path and the locked combinational core, replacing ad-hoc internally clocked DFFs.

Parameters:
- NCH, 8, number of locked channels; also the serial key length in bits.
- XNOR_MASK, {NCH{1'b0}}, per-channel polarity: 1 = XNOR key gate, 0 = XOR key gate.
- CNTW, 8, width of the saturating capture-event counter.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst_n  input  1  synchronous active-low reset.
- key_load  input  1  start or restart a serial key load.
- key_valid  input  1  key_sdi is valid this cycle.
- key_sdi  input  1  serial key bit, LSB (channel 0) first.
- trig  input  NCH  per-channel trigger level, the locally generated NOR condition.
- d_enc  input  NCH  encrypted channel signals.
- d_out  output  NCH  decrypted channel signals, combinational from d_enc.
- key_ready  output  1  registered; high while in ARMED.
- key_err  output  1  registered; parity error flag (see Optional Feature).
- cap_cnt  output  CNTW  saturating count of accepted capture events.

Behaviour:
Interface rules:
- One clock. Reset is synchronous and active-low (rst_n sampled on the clk rising edge).

Reset (rst_n=0 at a clk edge):
- state=IDLE; key_reg=0, lib=0, trig_q=0, bit counter=0, cap_cnt=0; key_ready=0, key_err=0.
- d_out therefore equals d_enc^XNOR_MASK.
- Reset mid-load or mid-ARMED discards everything; no partial key survives.

State machine (2-bit register):
- IDLE: key_load=1 -> SHIFT with cnt=0.
- SHIFT:
  - Each key_valid=1 cycle: key_reg <= {key_sdi, key_reg[NCH-1:1]} and cnt <= cnt+1.
  - key_valid=0: hold state and contents; no timeout.
  - When cnt==NCH-1 and key_valid=1: take the last bit, then -> ARMED. key_ready=1 from the next cycle.
  - key_load=1 in SHIFT: restart with cnt=0. key_load has priority over a simultaneous key_valid, whose bit is dropped.
- ARMED: key_load=1 -> SHIFT, key_ready=0 next cycle. lib is held, not cleared, while the new key loads.
- ERROR: exists only with the macro; see Optional Feature.

Trigger capture:
- trig_q <= trig every cycle in every state, except under reset.
- Edge detect: rise[i] = trig[i] & ~trig_q[i].
- In ARMED, a rise[i] seen at edge k gives lib[i]=key_reg[i] after edge k, i.e. d_out reflects it one cycle after trig is first sampled high.
- Rises outside ARMED are ignored. A trig already high when ARMED is entered does not capture until it falls and rises again.
- Multiple channels rising in the same cycle all capture.
- cap_cnt increments by 1 per cycle with at least one accepted rise; it saturates at 2^CNTW-1 and clears only on reset.

Output path:
- d_out[i] = d_enc[i] ^ lib[i] ^ XNOR_MASK[i], purely combinational. Zero latency from d_enc.
- Correct key with a captured channel gives d_out == plaintext.

Optional Feature:
Macro: LIBAR_PARITY_EN
- Defined:
  - SHIFT expects NCH+1 bits. The final bit is even parity over the key.
  - Match -> ARMED.
  - Mismatch -> ERROR with key_err=1. In ERROR, lib is cleared to 0 and triggers are ignored.
  - Only key_load (-> SHIFT, key_err=0 next cycle) or reset leaves ERROR.
- Undefined:
  - NCH bits per load; no ERROR state; key_err tied 0.

Test Plan:
1. Reset with NCH=8, d_enc=8'hA5, XNOR_MASK=0 -> d_out=8'hA5, key_ready=0, cap_cnt=0.
2. Load key 8'h3C LSB-first with key_valid gaps, then assert trig=8'hFF for one cycle -> key_ready=1 after the 8th bit. lib=8'h3C one cycle after trig high, so d_out=d_enc^8'h3C; cap_cnt=1.
3. Hold trig=8'h01 high across the ARMED entry -> no capture and lib stays 0. Drop and re-raise trig[0] -> lib[0] captured, cap_cnt=1.
4. key_load pulsed after 5 bits of a first key, then full key 8'hF0 -> key_reg=8'hF0; the first partial key is fully discarded.
5. rst_n=0 for one cycle while ARMED with lib=8'h3C -> next cycle lib=0, state IDLE, d_out=d_enc.
6. (LIBAR_PARITY_EN) key 8'h3C with parity 1 (wrong) -> key_err=1 and state ERROR. Triggers then give no capture. key_load clears key_err the next cycle.
